load_data_aligner: RTL and testbench
====================================

# load_data_aligner

Load-side counterpart of the store byte-lane mask generator: accepts one load request at a time from the execute stage, issues a word-aligned read to data memory, waits for the read response, then extracts the addressed byte, halfword or word and zero- or sign-extends it to 32 bits for writeback. It sits between the ALU address output and the data memory read port. It rejects misaligned accesses, matching the store side, which suppresses halfword stores at offset 3. It flags a memory timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in MEM_WAIT before the load is aborted with an error; legal range 1..65535.

Ports:
- clk  in  1  clock; everything is clocked on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  32  byte address from the ALU.
- req_funct3  in  3  RISC-V load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is illegal.
- req_rd  in  5  destination register tag, returned unchanged.
- mem_re  out  1  read strobe, one-cycle pulse.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word; little-endian, byte 0 is bits 7:0.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  extended load result.
- resp_rd  out  5  tag of the completed load.
- resp_err  out  1  misaligned address, illegal funct3, or timeout.

## Operation
- States: IDLE, MEM_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3 and rd.
  - Legal and aligned request: go to MEM_WAIT.
  - Otherwise: go to RESP with resp_err=1 and resp_data=0; mem_re is never asserted.
- Alignment rules:
  - Byte loads: any offset.
  - Halfword loads: offset 0, 1 or 2 legal; offset 3 is misaligned.
  - Word loads: offset 0 only.
- MEM_WAIT:
  - mem_re=1 in the first cycle only.
  - mem_addr is held for the whole state.
  - Wait counter is cleared on entry and increments each cycle.
- On mem_rvalid in MEM_WAIT: select the lane at offset addr[1:0] and extend it, then go to RESP.
  - LB/LH: sign-extend from bit 7 or bit 15 of the selected lane.
  - LBU/LHU: zero-extend.
  - LW: pass the word through.
  - Halfword at offset 1: uses bytes 2:1.
- Timeout: if the counter reaches TIMEOUT without mem_rvalid, go to RESP with resp_err=1 and resp_data=0.
- RESP:
  - resp_valid=1; resp_data, resp_rd and resp_err are held stable.
  - On resp_ready, go to IDLE.
- mem_rvalid outside MEM_WAIT is ignored. This includes a late response after a timeout.

## Timing
- Reset: state IDLE. All outputs are 0 except req_ready=1; the counter is 0.
- Request accept: the handshake in cycle N puts the block in MEM_WAIT in cycle N+1, with mem_re=1 in N+1 only.
- mem_rvalid may arrive in the same cycle as mem_re (zero-latency memory). In that case resp_valid=1 in N+2.
- Minimum latency from accept to resp_valid is 2 cycles; an error path takes 1 cycle.
- resp_valid and resp_ready in the same cycle: IDLE next cycle, so req_ready=1 in N+3 at the earliest.
- Timeout: resp_valid rises TIMEOUT+1 cycles after mem_re.
- mem_rvalid in the same cycle the counter hits TIMEOUT: data wins and resp_err=0.
- Reset mid-operation: return to IDLE immediately, drop the pending load, and produce no response.
- Throughput: one load outstanding; at most one load every 3 cycles.

## Test plan
- mem_rdata=0x808182F3, req_addr=0x100:
  - LB: 0xFFFFFFF3.
  - LBU: 0x000000F3.
  - LW: 0x808182F3.
  - Each with resp_err=0 and mem_addr=0x100.
- Same data, LH at 0x102 gives 0xFFFF8081; LHU at 0x100 gives 0x000082F3; LH at 0x101 gives 0xFFFF8182; LBU at 0x103 gives 0x00000080.
- LH at 0x103, LW at 0x102, and funct3=011 each give resp_err=1, resp_data=0, mem_re never asserted, and resp_valid one cycle after accept.
- TIMEOUT=4 with no mem_rvalid: resp_err=1 exactly 5 cycles after mem_re. A later mem_rvalid has no effect.
- Hold resp_ready=0 for 3 cycles: resp_valid, resp_data and resp_rd are stable and req_ready=0. Raising resp_ready leads to IDLE the next cycle.
- Assert rst during MEM_WAIT, then deliver mem_rvalid: no resp_valid, and req_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/load_data_aligner.sv
// load_data_aligner
// Accepts one load request at a time, issues a word-aligned read to data
// memory, waits for the read word and returns the addressed byte, halfword
// or word zero- or sign-extended to 32 bits for writeback. Misaligned
// accesses, illegal load types and memory timeouts return resp_err=1 with
// resp_data=0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       request handshake; req_ready high only in IDLE
//   req_addr, req_funct3      byte address and RISC-V load type
//   req_rd                    destination tag, returned as resp_rd
//   mem_re, mem_addr          one-cycle read strobe and word address
//   mem_rvalid, mem_rdata     read response (little-endian word)
//   resp_valid/resp_ready     result handshake
//   resp_data, resp_rd        extended result and its tag
//   resp_err                  misaligned, illegal funct3 or timeout
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high; while valid is high and ready is low, the payload is held.
module load_data_aligner #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt;

    logic        f3_legal;
    logic        aligned;
    logic        req_ok;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Legality and alignment are judged on the incoming request so the
    // IDLE state can route straight to RESP on an error.
    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b0;
        case (req_funct3[1:0])
            2'b00:   aligned = 1'b1;                      // byte: any offset
            2'b01:   aligned = (req_addr[1:0] != 2'b11);  // half: not offset 3
            2'b10:   aligned = (req_addr[1:0] == 2'b00);  // word: offset 0 only
            default: aligned = 1'b0;
        endcase
    end

    assign req_ok = f3_legal && aligned;

    // Shifting the word right by the byte offset puts the addressed lane in
    // the low bits; a halfword at offset 1 thus picks bytes 2:1.
    assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'h0, lane[7:0]};
            3'b101:  load_data = {16'h0, lane[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= 32'h0;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            cnt       <= 16'd0;
            mem_re    <= 1'b0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        rd_q     <= req_rd;
                        if (req_ok) begin
                            state  <= MEM_WAIT;
                            mem_re <= 1'b1;
                            cnt    <= 16'd0;
                        end else begin
                            state     <= RESP;
                            resp_err  <= 1'b1;
                            resp_data <= 32'h0;
                        end
                    end
                end
                MEM_WAIT: begin
                    mem_re <= 1'b0;
                    // Data takes priority over a timeout in the same cycle.
                    if (mem_rvalid) begin
                        state     <= RESP;
                        resp_data <= load_data;
                        resp_err  <= 1'b0;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state     <= RESP;
                        resp_data <= 32'h0;
                        resp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign resp_rd    = rd_q;

endmodule

// File: tb/tb_load_data_aligner.sv
module tb_load_data_aligner;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int checks;
    int failures;

    load_data_aligner #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];
    int   n_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns with the clock #1 past the
    // accepting edge.
    task automatic send_req(input logic [31:0] a, input logic [2:0] f, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f;
        req_rd     = rd;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic finish_resp(input string name);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({name, " idle req_ready"}, 32'(req_ready), 32'd1);
        check({name, " idle resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("v%0d", i);
        send_req(vecs[i].addr, vecs[i].f3, vecs[i].rd);
        if (!vecs[i].exp_err) begin
            check({nm, " mem_re"}, 32'(mem_re), 32'd1);
            check({nm, " mem_addr"}, mem_addr, {vecs[i].addr[31:2], 2'b00});
            check({nm, " early resp_valid"}, 32'(resp_valid), 32'd0);
            // zero-latency memory: data in the same cycle as mem_re
            mem_rvalid = 1'b1;
            mem_rdata  = vecs[i].rdata;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            check({nm, " mem_re pulse"}, 32'(mem_re), 32'd0);
        end else begin
            check({nm, " mem_re err"}, 32'(mem_re), 32'd0);
        end
        check({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({nm, " resp_data"}, resp_data, vecs[i].exp_data);
        check({nm, " resp_err"}, 32'(resp_err), 32'(vecs[i].exp_err));
        check({nm, " resp_rd"}, 32'(resp_rd), 32'(vecs[i].rd));
        finish_resp(nm);
    endtask

    int got;
    logic [31:0] held_data;

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_rd     = 5'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        resp_ready = 1'b0;

        n_vec = 0;
        vecs[n_vec++] = '{32'h0000_0100, 3'b000, 5'd1,  32'h808182F3, 32'hFFFFFFF3, 1'b0}; // LB
        vecs[n_vec++] = '{32'h0000_0100, 3'b100, 5'd2,  32'h808182F3, 32'h000000F3, 1'b0}; // LBU
        vecs[n_vec++] = '{32'h0000_0100, 3'b010, 5'd3,  32'h808182F3, 32'h808182F3, 1'b0}; // LW
        vecs[n_vec++] = '{32'h0000_0102, 3'b001, 5'd4,  32'h808182F3, 32'hFFFF8081, 1'b0}; // LH @2
        vecs[n_vec++] = '{32'h0000_0100, 3'b101, 5'd5,  32'h808182F3, 32'h000082F3, 1'b0}; // LHU @0
        vecs[n_vec++] = '{32'h0000_0101, 3'b001, 5'd6,  32'h808182F3, 32'hFFFF8182, 1'b0}; // LH @1
        vecs[n_vec++] = '{32'h0000_0103, 3'b100, 5'd7,  32'h808182F3, 32'h00000080, 1'b0}; // LBU @3
        vecs[n_vec++] = '{32'h1000_0105, 3'b000, 5'd8,  32'h7F00FF01, 32'hFFFFFFFF, 1'b0}; // LB @1
        vecs[n_vec++] = '{32'h1000_0106, 3'b001, 5'd9,  32'h7F00FF01, 32'h00007F00, 1'b0}; // LH @2 pos
        vecs[n_vec++] = '{32'h1000_0105, 3'b101, 5'd10, 32'h7F00FF01, 32'h000000FF, 1'b0}; // LHU @1
        vecs[n_vec++] = '{32'h1000_0107, 3'b000, 5'd11, 32'h7F00FF01, 32'h0000007F, 1'b0}; // LB @3
        vecs[n_vec++] = '{32'h0000_0103, 3'b001, 5'd12, 32'h808182F3, 32'h00000000, 1'b1}; // LH @3
        vecs[n_vec++] = '{32'h0000_0102, 3'b010, 5'd13, 32'h808182F3, 32'h00000000, 1'b1}; // LW @2
        vecs[n_vec++] = '{32'h0000_0100, 3'b011, 5'd14, 32'h808182F3, 32'h00000000, 1'b1}; // f3=011
        vecs[n_vec++] = '{32'h0000_0100, 3'b110, 5'd15, 32'h808182F3, 32'h00000000, 1'b1}; // f3=110
        vecs[n_vec++] = '{32'h0000_0101, 3'b010, 5'd31, 32'h808182F3, 32'h00000000, 1'b1}; // LW @1

        // reset state
        step();
        step();
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst mem_re", 32'(mem_re), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst resp_data", resp_data, 32'h0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst resp_rd", 32'(resp_rd), 32'd0);
        rst = 1'b0;
        step();
        check("post-rst req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < n_vec; i++) run_vec(i);

        // two-cycle memory latency: mem_re is a single pulse, addr held
        send_req(32'h0000_0204, 3'b000, 5'd20);
        check("lat mem_re first", 32'(mem_re), 32'd1);
        step();
        check("lat mem_re second", 32'(mem_re), 32'd0);
        check("lat mem_addr held", mem_addr, 32'h0000_0204);
        check("lat req_ready", 32'(req_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0085;
        step();
        mem_rvalid = 1'b0;
        check("lat resp_valid", 32'(resp_valid), 32'd1);
        check("lat resp_data", resp_data, 32'hFFFFFF85);
        finish_resp("lat");

        // timeout: response TIMEOUT+1 = 5 cycles after mem_re
        send_req(32'h0000_0300, 3'b010, 5'd21);
        check("to mem_re", 32'(mem_re), 32'd1);
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (resp_valid) begin
                got = k;
                break;
            end
        end
        check("to latency", 32'(got), 32'd5);
        check("to resp_err", 32'(resp_err), 32'd1);
        check("to resp_data", resp_data, 32'h0);
        check("to resp_rd", 32'(resp_rd), 32'd21);
        // late response while in RESP has no effect
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        check("to late err", 32'(resp_err), 32'd1);
        check("to late data", resp_data, 32'h0);
        finish_resp("to");
        // late response in IDLE also ignored
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("to idle resp_valid", 32'(resp_valid), 32'd0);
        check("to idle req_ready", 32'(req_ready), 32'd1);

        // data in the same cycle the counter reaches TIMEOUT wins
        send_req(32'h0000_0400, 3'b010, 5'd22);
        for (int k = 0; k < 4; k++) step();
        check("edge no resp yet", 32'(resp_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        check("edge resp_valid", 32'(resp_valid), 32'd1);
        check("edge resp_err", 32'(resp_err), 32'd0);
        check("edge resp_data", resp_data, 32'hCAFE_F00D);
        finish_resp("edge");

        // backpressure: outputs held for 3 cycles with resp_ready low
        send_req(32'h0000_0500, 3'b001, 5'd23);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_9ABC;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        held_data  = 32'hFFFF9ABC;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d resp_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d resp_data", k), resp_data, held_data);
            check($sformatf("bp%0d resp_rd", k), 32'(resp_rd), 32'd23);
            check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            step();
        end
        finish_resp("bp");

        // reset during MEM_WAIT drops the load
        send_req(32'h0000_0600, 3'b010, 5'd24);
        check("rmw mem_re", 32'(mem_re), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        check("rmw req_ready", 32'(req_ready), 32'd1);
        check("rmw resp_valid", 32'(resp_valid), 32'd0);
        check("rmw mem_re", 32'(mem_re), 32'd0);
        step();
        check("rmw resp_valid later", 32'(resp_valid), 32'd0);

        // block still works after the aborted load
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
